// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with almost flags, count, sticky errors, flush
// Registered read data; status is decoded from the registered pointers only.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_LVL = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LVL = CW'(AE_LEVEL);
  localparam logic [CW-1:0] PTR_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [CW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_acc, wr_acc, mem_we;

  assign count        = wptr_q - rptr_q;
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_out     = data_out_q;

  // A write at full is only admitted when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc      = cs & rd_en & ~empty;
    wr_acc      = cs & wr_en & (~full | rd_acc);
    mem_we      = 1'b0;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    data_out_d  = data_out_q;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      data_out_d  = '0;
    end else begin
      if (wr_acc) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rptr_d     = rptr_q + PTR_ONE;
        data_out_d = mem[rptr_q[AW-1:0]];
      end
      if (cs & wr_en & ~wr_acc) overflow_d = 1'b1;
      if (cs & rd_en & ~rd_acc) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      data_out_q  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags
// Driver updates a queue-based model and pushes expectations; a negedge monitor compares.
module tb_sync_fifo_flags;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]    count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cnt;
    logic [31:0] dout;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_q[$];
  logic [31:0] model_dout;
  logic        model_ovf, model_unf;

  sync_fifo_flags #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .data_in(data_in), .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input logic [31:0] dout,
                           input logic ovf, input logic unf);
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, " full"}, 32'(full), 32'(cnt == D));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= AF));
    chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(unf));
    chk({tag, " data_out"}, data_out, dout);
  endtask

  task automatic model_reset();
    model_q.delete();
    model_dout = '0;
    model_ovf  = 1'b0;
    model_unf  = 1'b0;
  endtask

  // One clock edge: drive inputs, apply the FIFO rules to the model, queue the expectation.
  task automatic step(input logic c, input logic w, input logic r, input logic f, input logic [31:0] d);
    logic ra, wa;
    exp_t e;
    cs = c; wr_en = w; rd_en = r; flush = f; data_in = d;
    @(posedge clk);
    ra = c && r && (model_q.size() > 0);
    wa = c && w && ((model_q.size() < D) || ra);
    if (f) begin
      model_reset();
    end else begin
      if (ra) model_dout = model_q.pop_front();
      if (wa) model_q.push_back(d);
      if (c && w && !wa) model_ovf = 1'b1;
      if (c && r && !ra) model_unf = 1'b1;
    end
    e.cnt = model_q.size(); e.dout = model_dout; e.ovf = model_ovf; e.unf = model_unf;
    sb.push_back(e);
    #1;
  endtask

  task automatic wr(input logic [31:0] d); step(1'b1, 1'b1, 1'b0, 1'b0, d); endtask
  task automatic rd(); step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_all("sb", e.cnt, e.dout, e.ovf, e.unf);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    check_all("reset", 0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ordered transfer
    wr(100); wr(200); wr(300);
    rd(); rd(); rd();

    // fill, overflow, drain
    for (int i = 1; i <= 9; i++) wr(32'(i));
    for (int i = 0; i < 8; i++) rd();

    // wrap-around rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) wr($urandom);
      for (int i = 0; i < 6; i++) rd();
    end

    // simultaneous access at full, then at empty
    for (int i = 0; i < 8; i++) wr(32'h10 + 32'(i));
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hAA);
    for (int i = 0; i < 8; i++) rd();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'hBB);
    rd();

    // flush with count 5 and overflow set
    for (int i = 0; i < 9; i++) wr(32'h20 + 32'(i));
    rd(); rd(); rd();
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h77);
    wr(32'h55); rd();

    // async reset between edges with count 4
    for (int i = 0; i < 4; i++) wr(32'h30 + 32'(i));
    rd();
    wr(32'h40);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset", 0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    rd();

    // chip select low holds everything
    wr(32'h61); wr(32'h62);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h99);
    rd(); rd();

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) == 0, $urandom);

    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
